// File: rtl/vc_demux_buf.sv
// vc_demux_buf: input-side VC demultiplexer with per-VC FIFOs.
// Steers each incoming link flit into the FIFO of its VC, exposes every
// VC head to the router core, and returns one credit per dequeued flit.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_     - synchronous reset, active-high
//   ivalid   - incoming flit valid
//   idata    - incoming flit data
//   ivch     - destination VC of the incoming flit
//   deq      - per-VC pop request from the core
//   ovalid   - per-VC head valid (FIFO non-empty)
//   odata    - per-VC head data, VC v at [v*DATAW +: DATAW]
//   ocredit  - per-VC credit-return pulse, one cycle after a dequeue
//   ocount   - per-VC occupancy, VC v at [v*CW +: CW]
//   overflow - sticky flag: a flit was dropped (full VC or bad VC id)
module vc_demux_buf #(
    parameter  int DATAW = 32,
    parameter  int NVCH  = 2,
    parameter  int DEPTH = 4,
    localparam int VCW   = (NVCH > 1) ? $clog2(NVCH) : 1,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  ivalid,
    input  logic [DATAW-1:0]      idata,
    input  logic [VCW-1:0]        ivch,
    input  logic [NVCH-1:0]       deq,
    output logic [NVCH-1:0]       ovalid,
    output logic [NVCH*DATAW-1:0] odata,
    output logic [NVCH-1:0]       ocredit,
    output logic [NVCH*CW-1:0]    ocount,
    output logic                  overflow
);

    localparam logic [VCW:0] NVCH_L = (VCW+1)'(NVCH);

    logic [DATAW-1:0] r_mem   [NVCH][DEPTH];
    logic [PW-1:0]    r_wptr  [NVCH];
    logic [PW-1:0]    r_rptr  [NVCH];
    logic [CW-1:0]    r_count [NVCH];
    logic [NVCH-1:0]  r_credit;
    logic             r_overflow;

    logic [NVCH-1:0]  w_enq_ok;
    logic [NVCH-1:0]  w_deq_ok;
    logic             w_drop;
    logic             w_vch_bad;

    // A full VC still accepts a flit when it is popped in the same cycle,
    // since the dequeue frees the slot the write lands in.
    always_comb begin
        w_enq_ok  = '0;
        w_deq_ok  = '0;
        w_vch_bad = ({1'b0, ivch} >= NVCH_L);
        w_drop    = ivalid && w_vch_bad;
        for (int unsigned v = 0; v < NVCH; v++) begin
            w_deq_ok[v] = deq[v] && (r_count[v] != '0);
            if (ivalid && !w_vch_bad && (ivch == VCW'(v))) begin
                if ((r_count[v] != CW'(DEPTH)) || deq[v]) begin
                    w_enq_ok[v] = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NVCH; v++) begin
            if (w_enq_ok[v]) begin
                r_mem[v][r_wptr[v]] <= idata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int unsigned v = 0; v < NVCH; v++) begin
                r_wptr[v]  <= '0;
                r_rptr[v]  <= '0;
                r_count[v] <= '0;
            end
            r_credit   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_deq_ok;
            for (int unsigned v = 0; v < NVCH; v++) begin
                if (w_enq_ok[v]) begin
                    r_wptr[v] <= r_wptr[v] + PW'(1);
                end
                if (w_deq_ok[v]) begin
                    r_rptr[v] <= r_rptr[v] + PW'(1);
                end
                case ({w_enq_ok[v], w_deq_ok[v]})
                    2'b10:   r_count[v] <= r_count[v] + CW'(1);
                    2'b01:   r_count[v] <= r_count[v] - CW'(1);
                    default: r_count[v] <= r_count[v];
                endcase
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        ovalid = '0;
        odata  = '0;
        ocount = '0;
        for (int unsigned v = 0; v < NVCH; v++) begin
            ovalid[v]               = (r_count[v] != '0);
            odata[v*DATAW +: DATAW] = r_mem[v][r_rptr[v]];
            ocount[v*CW +: CW]      = r_count[v];
        end
    end

    assign ocredit  = r_credit;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_vc_demux_buf.sv
// Testbench for vc_demux_buf (DATAW=32, NVCH=2, DEPTH=4).
// Stimulus pushes accepted flits into per-VC expected queues; a monitor on
// the falling edge pops and compares heads on every dequeue, and tracks
// occupancy, head valid, credit pulses and the sticky overflow flag.
module tb_vc_demux_buf;

    logic        clk;
    logic        rst_;
    logic        ivalid;
    logic [31:0] idata;
    logic [0:0]  ivch;
    logic [1:0]  deq;
    logic [1:0]  ovalid;
    logic [63:0] odata;
    logic [1:0]  ocredit;
    logic [5:0]  ocount;
    logic        overflow;

    vc_demux_buf #(.DATAW(32), .NVCH(2), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid   (ivalid),
        .idata    (idata),
        .ivch     (ivch),
        .deq      (deq),
        .ovalid   (ovalid),
        .odata    (odata),
        .ocredit  (ocredit),
        .ocount   (ocount),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          credit_seen = 0;
    bit          mon_en = 1'b0;
    logic [1:0]  exp_credit = 2'b00;
    logic        exp_ovf = 1'b0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one flit (optionally with deq) for one edge; the model decides
    // acceptance from the occupancy it holds before the edge.
    task automatic enq(input int v, input logic [31:0] d, input logic [1:0] dq);
        int sz;
        bit acc;
        ivalid = 1'b1;
        idata  = d;
        ivch   = v[0];
        deq    = dq;
        sz     = (v == 0) ? q0.size() : q1.size();
        acc    = (sz < 4) || dq[v];
        tick();
        if (acc) begin
            if (v == 0) q0.push_back(d);
            else        q1.push_back(d);
        end else begin
            exp_ovf = 1'b1;
        end
        ivalid = 1'b0;
        deq    = 2'b00;
    endtask

    task automatic pop(input logic [1:0] m);
        deq = m;
        tick();
        deq = 2'b00;
    endtask

    task automatic do_reset(input logic [1:0] dq);
        rst_ = 1'b1;
        deq  = dq;
        tick();
        q0.delete();
        q1.delete();
        exp_ovf = 1'b0;
        rst_ = 1'b0;
        deq  = 2'b00;
    endtask

    // Monitor: compare against the model, then consume heads that the
    // coming edge will dequeue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ocredit", ocredit, exp_credit);
            credit_seen += int'(ocredit[0]) + int'(ocredit[1]);
            chk("overflow", overflow, exp_ovf);
            chk("ovalid0", ovalid[0], q0.size() != 0);
            chk("ovalid1", ovalid[1], q1.size() != 0);
            chk("ocount0", ocount[2:0], q0.size());
            chk("ocount1", ocount[5:3], q1.size());
            exp_credit = 2'b00;
            if (!rst_) begin
                if (deq[0] && q0.size() != 0) begin
                    exp_credit[0] = 1'b1;
                    chk("head0", odata[31:0], q0.pop_front());
                end
                if (deq[1] && q1.size() != 0) begin
                    exp_credit[1] = 1'b1;
                    chk("head1", odata[63:32], q1.pop_front());
                end
            end
        end
    end

    initial begin
        rst_   = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        ivch   = '0;
        deq    = 2'b00;
        tick();
        tick();
        rst_   = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_ovalid", ovalid, 2'b00);
        chk("rst_ocredit", ocredit, 2'b00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_ocount", ocount, 6'd0);

        // Single flit: visible one cycle after write, credit one cycle after pop
        enq(0, 32'hA1, 2'b00);
        chk("a1_valid", ovalid, 2'b01);
        chk("a1_data", odata[31:0], 32'hA1);
        tick();
        pop(2'b01);
        chk("a1_credit", ocredit, 2'b01);
        chk("a1_empty", ovalid, 2'b00);
        tick();
        chk("a1_credit_end", ocredit, 2'b00);

        // Interleaved VCs
        enq(0, 32'h10, 2'b00);
        enq(1, 32'h11, 2'b00);
        enq(0, 32'h12, 2'b00);
        enq(1, 32'h13, 2'b00);
        chk("il_count", ocount, {3'd2, 3'd2});
        chk("il_head0", odata[31:0], 32'h10);
        chk("il_head1", odata[63:32], 32'h11);
        pop(2'b11);
        chk("il_head0b", odata[31:0], 32'h12);
        chk("il_head1b", odata[63:32], 32'h13);
        pop(2'b11);
        chk("il_empty", ovalid, 2'b00);

        // Full VC1: drop without deq, accept with deq
        for (int i = 0; i < 4; i++) enq(1, 32'h20 + i, 2'b00);
        chk("full_count", ocount[5:3], 3'd4);
        enq(1, 32'hFF, 2'b00);
        chk("drop_ovf", overflow, 1'b1);
        chk("drop_count", ocount[5:3], 3'd4);
        tick();
        chk("ovf_sticky", overflow, 1'b1);
        enq(1, 32'h24, 2'b10);
        chk("fulldeq_count", ocount[5:3], 3'd4);
        chk("fulldeq_head", odata[63:32], 32'h21);
        chk("fulldeq_ovf", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pop(2'b10);
        chk("drain_empty", ovalid, 2'b00);
        tick();

        do_reset(2'b00);
        chk("rst2_ovf", overflow, 1'b0);

        // Enqueue and deq together on an empty VC: only the enqueue happens
        enq(0, 32'h55, 2'b01);
        chk("emptydeq_valid", ovalid, 2'b01);
        chk("emptydeq_credit", ocredit, 2'b00);
        chk("emptydeq_data", odata[31:0], 32'h55);

        // Simultaneous dequeue on both VCs
        enq(1, 32'h66, 2'b00);
        pop(2'b11);
        chk("both_credit", ocredit, 2'b11);
        tick();
        chk("both_credit_end", ocredit, 2'b00);
        pop(2'b11);
        chk("empty_credit", ocredit, 2'b00);
        chk("empty_valid", ovalid, 2'b00);
        tick();

        // Pointer wrap on VC0
        credit_seen = 0;
        for (int i = 0; i < 10; i++) begin
            enq(0, i, 2'b00);
            pop(2'b01);
        end
        tick();
        chk("wrap_credits", credit_seen, 10);
        chk("wrap_empty", ocount, 6'd0);

        // Reset mid-fill with a concurrent deq: no pop, no credit
        for (int i = 0; i < 3; i++) enq(0, 32'h70 + i, 2'b00);
        chk("mid_count", ocount[2:0], 3'd3);
        do_reset(2'b01);
        chk("mid_rst_count", ocount[2:0], 3'd0);
        chk("mid_rst_credit", ocredit, 2'b00);
        tick();
        chk("mid_rst_credit2", ocredit, 2'b00);
        chk("mid_rst_valid", ovalid, 2'b00);
        tick();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
